// File: rtl/pipe_mux_stage.sv
// ============================================================================
// pipe_mux_stage : N-way select mux fused with a registered stage and a
//                  2-entry skid buffer (registered in_ready, synchronous flush).
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_mux_stage #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   main_data_q, main_data_d;
    logic [SEL_W-1:0]   main_sel_q, main_sel_d;
    logic [WIDTH-1:0]   skid_data_q, skid_data_d;
    logic [SEL_W-1:0]   skid_sel_q, skid_sel_d;
    logic               in_ready_q;
    logic               sel_err_q, sel_err_d;

    logic [WIDTH-1:0]   w_mux_word;
    logic               w_sel_hit;
    logic               w_accept;
    logic               w_pop;

    // Out-of-range selects fall back to input 0 and are flagged via w_sel_hit.
    always_comb begin
        w_mux_word = in_data[WIDTH-1:0];
        w_sel_hit  = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                w_mux_word = in_data[k*WIDTH +: WIDTH];
                w_sel_hit  = 1'b1;
            end
        end
    end

    assign w_accept = in_valid && in_ready_q;
    assign w_pop    = (state_q != EMPTY) && out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_sel_d  = main_sel_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        sel_err_d   = w_accept && !w_sel_hit && !flush;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (w_accept) begin
                        state_d     = ONE;
                        main_data_d = w_mux_word;
                        main_sel_d  = sel;
                    end
                end
                ONE: begin
                    if (w_accept && w_pop) begin
                        main_data_d = w_mux_word;
                        main_sel_d  = sel;
                    end else if (w_accept) begin
                        state_d     = FULL;
                        skid_data_d = w_mux_word;
                        skid_sel_d  = sel;
                    end else if (w_pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        state_d     = ONE;
                        main_data_d = skid_data_q;
                        main_sel_d  = skid_sel_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_sel_q  <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            in_ready_q  <= 1'b1;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_sel_q  <= main_sel_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            in_ready_q  <= (state_d != FULL);
            sel_err_q   <= sel_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_data_q;
    assign out_sel   = main_sel_q;
    assign sel_err   = sel_err_q;

endmodule

`default_nettype wire
